run_ctrl: RTL and testbench

- Host-side run sequencer directly upstream of the processor top level.
- Accepts a four-phase start request and latches a program select.
- Holds the core in reset for a fixed number of cycles, then releases it and counts execution cycles until the core raises done or a timeout expires.
- Re-freezes the core in reset and reports cycle count and status to the host/testbench.

---
 rtl/run_ctrl_pkg.sv | 21 ++
 rtl/run_ctrl.sv | 114 +++++++++++
 tb/tb_run_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the host-side run sequencer.
// State encoding is 2-bit; default widths/limits match the nominal system build.
// The hold counter is sized for reset-hold lengths of up to 15 cycles.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_CW         = 16;
  localparam int DEF_PW         = 2;
  localparam int DEF_TIMEOUT    = 50000;
  localparam int DEF_RST_CYCLES = 2;

  // Width of the reset-hold down-counter (RST_CYCLES is limited to 1..15).
  localparam int HOLD_W = 4;

endpackage

// File: rtl/run_ctrl.sv
// Run sequencer: four-phase start handshake, core reset hold, cycle counting, done/timeout report.
// Latency: req rise to core_reset fall RST_CYCLES+1 cycles; core_done to ack 1 cycle; req fall to ack fall 1 cycle.
// Backpressure: host holds req until ack, then drops it; dropping req early aborts the run without ack.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CW         = DEF_CW,
  parameter int PW         = DEF_PW,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [PW-1:0] prog_sel,
  input  logic          core_done,
  output logic          core_reset,
  output logic [PW-1:0] prog_id,
  output logic          busy,
  output logic          ack,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  localparam logic [CW-1:0]     CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]     CNT_MAX   = CW'(TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES - 1);

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_q, hold_nxt;
  logic [CW-1:0]       cnt_q, cnt_nxt;
  logic                to_q, to_nxt;
  logic [PW-1:0]       pid_q, pid_nxt;

  // Next-state and datapath update; every register holds unless a transition says otherwise.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_q;
    cnt_nxt   = cnt_q;
    to_nxt    = to_q;
    pid_nxt   = pid_q;
    unique case (state)
      IDLE: begin
        // Previous results stay visible here until a new run is accepted.
        if (req) begin
          pid_nxt   = prog_sel;
          cnt_nxt   = '0;
          to_nxt    = 1'b0;
          hold_nxt  = HOLD_INIT;
          state_nxt = RESET;
        end
      end
      RESET: begin
        // core_done is deliberately ignored while the core is held in reset.
        if (!req) begin
          state_nxt = IDLE;
        end else if (hold_q == '0) begin
          state_nxt = RUN;
        end else begin
          hold_nxt = hold_q - HOLD_W'(1);
        end
      end
      RUN: begin
        if (!req) begin
          // Abort: keep the partial count, no timeout flag.
          state_nxt = IDLE;
        end else if (core_done) begin
          // Done has priority over a coincident timeout.
          state_nxt = DONE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_nxt   = CNT_MAX;
          to_nxt    = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; async reset returns everything to a clean idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      hold_q <= '0;
      cnt_q  <= '0;
      to_q   <= 1'b0;
      pid_q  <= '0;
    end else begin
      state  <= state_nxt;
      hold_q <= hold_nxt;
      cnt_q  <= cnt_nxt;
      to_q   <= to_nxt;
      pid_q  <= pid_nxt;
    end
  end

  // Outputs decode from registers only, so no input reaches an output combinationally.
  always_comb begin
    core_reset  = (state != RUN);
    busy        = (state == RESET) || (state == RUN);
    ack         = (state == DONE);
    timeout     = to_q;
    cycle_count = cnt_q;
    prog_id     = pid_q;
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: table of runs with a scoreboard queue, plus reset sequences.
// Inputs change and outputs are sampled on the falling clock edge.
// Every wait on the DUT is bounded; an expired bound counts as a failure.
module tb_run_ctrl;

  localparam int CW   = 16;
  localparam int PW   = 2;
  localparam int RSTC = 2;
  localparam int TMO  = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [PW-1:0] prog_sel;
  logic          core_done;
  logic          core_reset;
  logic [PW-1:0] prog_id;
  logic          busy;
  logic          ack;
  logic          timeout;
  logic [CW-1:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [PW-1:0] sel;
    int            done_at;   // RUN cycle in which core_done is raised (0 = never)
    int            abort_at;  // RUN cycle in which req is dropped (0 = never)
    bit            spur;      // core_done held during RESET, prog_sel toggled during RUN
    logic [CW-1:0] exp_count;
    logic          exp_to;
    logic          exp_ack;
    int            exp_exit;  // RUN cycle after which busy must be low
  } vec_t;

  vec_t tbl[6];
  vec_t exp_q[$];

  run_ctrl #(
    .CW(CW), .PW(PW), .RST_CYCLES(RSTC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(rst_n), .req(req), .prog_sel(prog_sel), .core_done(core_done),
    .core_reset(core_reset), .prog_id(prog_id), .busy(busy), .ack(ack),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   r;
    bit   left;
    @(negedge clk);
    prog_sel  = v.sel;
    req       = 1'b1;
    core_done = v.spur;
    exp_q.push_back(v);
    for (int i = 0; i < RSTC; i++) begin
      @(negedge clk);
      check("hold core_reset", 32'(core_reset), 1);
      check("hold busy", 32'(busy), 1);
    end
    @(negedge clk);
    check("run core_reset", 32'(core_reset), 0);
    core_done = 1'b0;
    r    = 1;
    left = 1'b0;
    while (!left && r <= 200) begin
      if (v.done_at == r) core_done = 1'b1;
      if (v.abort_at == r) req = 1'b0;
      if (v.spur) prog_sel = ~prog_sel;
      @(negedge clk);
      if (!busy) left = 1'b1;
      else r++;
    end
    core_done = 1'b0;
    if (!left) check("run exit bound", 0, 1);
    e = exp_q.pop_front();
    check("exit cycle", r, e.exp_exit);
    check("ack", 32'(ack), 32'(e.exp_ack));
    check("timeout", 32'(timeout), 32'(e.exp_to));
    check("cycle_count", 32'(cycle_count), 32'(e.exp_count));
    check("prog_id", 32'(prog_id), 32'(e.sel));
    check("frozen core_reset", 32'(core_reset), 1);
    if (e.exp_ack) begin
      @(negedge clk);
      check("ack held", 32'(ack), 1);
      req = 1'b0;
      @(negedge clk);
      check("ack drop", 32'(ack), 0);
      check("count kept in idle", 32'(cycle_count), 32'(e.exp_count));
    end else begin
      @(negedge clk);
      check("no ack after abort", 32'(ack), 0);
      check("abort core_reset", 32'(core_reset), 1);
    end
    req = 1'b0;
  endtask

  initial begin
    //        sel   done abort spur count to ack exit
    tbl[0] = '{2'd1, 37,  0,   0,   16'd36,  1'b0, 1'b1, 37};
    tbl[1] = '{2'd2, 0,   0,   0,   16'd100, 1'b1, 1'b1, 100};
    tbl[2] = '{2'd3, 100, 0,   0,   16'd99,  1'b0, 1'b1, 100};
    tbl[3] = '{2'd1, 0,   10,  0,   16'd9,   1'b0, 1'b0, 10};
    tbl[4] = '{2'd2, 5,   0,   1,   16'd4,   1'b0, 1'b1, 5};
    tbl[5] = '{2'd0, 1,   0,   0,   16'd0,   1'b0, 1'b1, 1};

    rst_n     = 1'b0;
    req       = 1'b0;
    prog_sel  = 2'd3;
    core_done = 1'b0;
    #12;
    check("rst core_reset", 32'(core_reset), 1);
    check("rst busy", 32'(busy), 0);
    check("rst ack", 32'(ack), 0);
    check("rst timeout", 32'(timeout), 0);
    check("rst cycle_count", 32'(cycle_count), 0);
    check("rst prog_id", 32'(prog_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle core_reset", 32'(core_reset), 1);
    check("idle busy", 32'(busy), 0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Async reset in the middle of a run.
    @(negedge clk);
    prog_sel = 2'd3;
    req      = 1'b1;
    repeat (RSTC + 1) @(negedge clk);
    repeat (20) @(negedge clk);
    check("pre-reset count", 32'(cycle_count), 20);
    check("pre-reset busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async core_reset", 32'(core_reset), 1);
    check("async busy", 32'(busy), 0);
    check("async ack", 32'(ack), 0);
    check("async cycle_count", 32'(cycle_count), 0);
    check("async prog_id", 32'(prog_id), 0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(tbl[0]);

    check("scoreboard empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
